// File: rtl/and_exerciser_if.sv
// Operand/result bus between the exerciser (master) and the AND array under test (slave).
`timescale 1ns/1ps
interface and_exerciser_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] drv_a;
   logic [WIDTH-1:0] drv_b;
   logic [WIDTH-1:0] dut_result;

   modport master (output drv_a, output drv_b, input dut_result);
   modport slave  (input drv_a, input drv_b, output dut_result);
endinterface

// File: rtl/and_exerciser.sv
// Exhaustive stimulus engine for a WIDTH-bit AND array: sweeps every operand pair,
// waits SETTLE cycles per vector and checks the returned result against a & b.
`timescale 1ns/1ps
module and_exerciser #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   and_exerciser_if.master      bus,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [2*WIDTH:0]     o_err_count,
   output logic                 o_fail_valid,
   output logic [WIDTH-1:0]     o_fail_a,
   output logic [WIDTH-1:0]     o_fail_b
);

   localparam int IW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;
   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK,
      DONE
   } state_t;

   state_t           r_state;
   logic [IW-1:0]    r_idx;
   logic [CW-1:0]    r_cnt;
   logic [EW-1:0]    r_err_count;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_fail_valid;
   logic [WIDTH-1:0] r_fail_a;
   logic [WIDTH-1:0] r_fail_b;

   logic [WIDTH-1:0] w_expected;
   logic             w_mismatch;

   // The operands are the two halves of the index register, so they are driven straight from flops.
   assign bus.drv_a = r_idx[IW-1:WIDTH];
   assign bus.drv_b = r_idx[WIDTH-1:0];

   assign w_expected = bus.drv_a & bus.drv_b;
   assign w_mismatch = (bus.dut_result != w_expected);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_err_count  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_fail_valid <= 1'b0;
         r_fail_a     <= '0;
         r_fail_b     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_idx        <= '0;
                  r_err_count  <= '0;
                  r_fail_valid <= 1'b0;
                  r_pass       <= 1'b0;
                  r_cnt        <= CW'(SETTLE);
                  r_busy       <= 1'b1;
                  r_state      <= WAIT;
               end
            end
            WAIT: begin
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (r_cnt == CW'(1)) begin
                  r_state <= CHECK;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            // An abort here discards this vector's compare, leaving the partial results untouched.
            CHECK: begin
               if (i_abort) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  if (w_mismatch) begin
                     r_err_count <= r_err_count + EW'(1);
                     if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= bus.drv_a;
                        r_fail_b     <= bus.drv_b;
                     end
                  end
                  if (&r_idx) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_idx   <= r_idx + IW'(1);
                     r_cnt   <= CW'(SETTLE);
                     r_state <= WAIT;
                  end
               end
            end
            DONE: begin
               r_pass  <= (r_err_count == '0);
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_pass       = r_pass;
   assign o_err_count  = r_err_count;
   assign o_fail_valid = r_fail_valid;
   assign o_fail_a     = r_fail_a;
   assign o_fail_b     = r_fail_b;

endmodule

// File: tb/tb_and_exerciser.sv
// Bench for and_exerciser: randomized sweeps against ideal, stuck-at and OR arrays,
// checked against a vector-level reference model of the whole sweep.
`timescale 1ns/1ps
module tb_and_exerciser;

   logic clk;
   logic rst_n;
   logic start0, abort0, start1, abort1;
   int   faultMode;

   logic       busy0, done0, pass0, failValid0;
   logic [8:0] errCount0;
   logic [3:0] failA0, failB0;
   logic       busy1, done1, pass1, failValid1;
   logic [8:0] errCount1;
   logic [3:0] failA1, failB1;

   int assertCount = 0;
   int failCount   = 0;

   and_exerciser_if #(.WIDTH(4)) bus0 ();
   and_exerciser_if #(.WIDTH(4)) bus1 ();

   and_exerciser #(.WIDTH(4), .SETTLE(2)) dut0 (
      .clk(clk), .rst_n(rst_n), .i_start(start0), .i_abort(abort0), .bus(bus0.master),
      .o_busy(busy0), .o_done(done0), .o_pass(pass0), .o_err_count(errCount0),
      .o_fail_valid(failValid0), .o_fail_a(failA0), .o_fail_b(failB0)
   );

   and_exerciser #(.WIDTH(4), .SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .i_start(start1), .i_abort(abort1), .bus(bus1.master),
      .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(errCount1),
      .o_fail_valid(failValid1), .o_fail_a(failA1), .o_fail_b(failB1)
   );

   // Array under test: 0 = ideal AND, 1 = result[3] stuck at 0, 2 = OR in place of AND.
   function automatic logic [3:0] arrayOut(input int mode, input logic [3:0] a, input logic [3:0] b);
      case (mode)
         1:       return (a & b) & 4'b0111;
         2:       return a | b;
         default: return a & b;
      endcase
   endfunction

   assign bus0.dut_result = arrayOut(faultMode, bus0.drv_a, bus0.drv_b);
   assign bus1.dut_result = bus1.drv_a & bus1.drv_b;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", tag, actual, expected);
      end
   endtask

   // Outcome of checking the first nVec vectors of a sweep in order.
   function automatic void sweepModel(input int mode, input int nVec, output int errs,
                                      output bit fv, output int fa, output int fb);
      errs = 0; fv = 0; fa = 0; fb = 0;
      for (int i = 0; i < nVec; i++) begin
         int a = i / 16;
         int b = i % 16;
         if (arrayOut(mode, 4'(a), 4'(b)) != 4'(a & b)) begin
            errs++;
            if (!fv) begin
               fv = 1; fa = a; fb = b;
            end
         end
      end
   endfunction

   // One sweep on the SETTLE=2 instance; edges are counted from the edge that accepts start.
   task automatic applyStimulus(input int mode, input int abortEdge, input int repulseEdge);
      int e, lastEdge, effEdge, expIdx, nVec, expErr, expFa, expFb, doneSeen;
      bit expFv;
      faultMode = mode;
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      e = 0;
      doneSeen = 0;
      checkOutput("busyRise", busy0, 1);
      checkOutput("errClear", errCount0, 0);
      checkOutput("fvClear", failValid0, 0);
      checkOutput("passClear", pass0, 0);
      lastEdge = (abortEdge != 0) ? abortEdge + 4 : 772;
      while (e < lastEdge) begin
         abort0 = (abortEdge != 0) && (e + 1 == abortEdge);
         start0 = (repulseEdge != 0) && (e + 1 == repulseEdge);
         @(posedge clk); #1;
         e++;
         abort0 = 1'b0;
         start0 = 1'b0;
         if (done0) doneSeen++;
         effEdge = (abortEdge != 0 && e >= abortEdge) ? abortEdge - 1 : e;
         expIdx  = (effEdge / 3 > 255) ? 255 : effEdge / 3;
         checkOutput($sformatf("busy@%0d", e), busy0,
                     (abortEdge != 0) ? (e < abortEdge) : (e <= 768));
         checkOutput($sformatf("done@%0d", e), done0, (abortEdge == 0) && (e == 768));
         checkOutput($sformatf("drvA@%0d", e), bus0.drv_a, expIdx / 16);
         checkOutput($sformatf("drvB@%0d", e), bus0.drv_b, expIdx % 16);
      end
      nVec = (abortEdge != 0) ? (abortEdge - 1) / 3 : 256;
      sweepModel(mode, nVec, expErr, expFv, expFa, expFb);
      checkOutput("donePulses", doneSeen, (abortEdge != 0) ? 0 : 1);
      checkOutput("errCount", errCount0, expErr);
      checkOutput("failValid", failValid0, expFv);
      checkOutput("pass", pass0, (abortEdge == 0) && (expErr == 0));
      if (expFv) begin
         checkOutput("failA", failA0, expFa);
         checkOutput("failB", failB0, expFb);
      end
   endtask

   task automatic applyStimulusFast();
      int e, doneSeen;
      @(posedge clk); #1;
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      e = 0;
      doneSeen = 0;
      while (e < 516) begin
         @(posedge clk); #1;
         e++;
         if (done1) doneSeen++;
         checkOutput($sformatf("s1done@%0d", e), done1, e == 512);
         checkOutput($sformatf("s1busy@%0d", e), busy1, e <= 512);
      end
      checkOutput("s1donePulses", doneSeen, 1);
      checkOutput("s1pass", pass1, 1);
      checkOutput("s1err", errCount1, 0);
      checkOutput("s1fv", failValid1, 0);
   endtask

   initial begin
      int mode;
      rst_n = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      faultMode = 0;
      #1;
      checkOutput("rstBusy", busy0, 0);
      checkOutput("rstDone", done0, 0);
      checkOutput("rstPass", pass0, 0);
      checkOutput("rstErr", errCount0, 0);
      checkOutput("rstFv", failValid0, 0);
      checkOutput("rstDrvA", bus0.drv_a, 0);
      checkOutput("rstDrvB", bus0.drv_b, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      checkOutput("stuckErrTotal", errCount0, 64);
      checkOutput("stuckFailA", failA0, 8);
      checkOutput("stuckFailB", failB0, 8);
      applyStimulus(2, 0, 0);
      checkOutput("orErrTotal", errCount0, 240);
      checkOutput("orFailA", failA0, 0);
      checkOutput("orFailB", failB0, 1);

      applyStimulus(int'($urandom_range(0, 2)), 0, int'($urandom_range(5, 700)));
      applyStimulus(1, 100, 0);
      applyStimulus(0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         mode = int'($urandom_range(0, 2));
         applyStimulus(mode, int'($urandom_range(1, 700)), 0);
      end
      applyStimulus(0, 0, 0);
      applyStimulusFast();

      // Reset in the middle of a stuck-at sweep.
      faultMode = 1;
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (300) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checkOutput("midRstBusy", busy0, 0);
      checkOutput("midRstDone", done0, 0);
      checkOutput("midRstPass", pass0, 0);
      checkOutput("midRstErr", errCount0, 0);
      checkOutput("midRstFv", failValid0, 0);
      checkOutput("midRstFailA", failA0, 0);
      checkOutput("midRstFailB", failB0, 0);
      checkOutput("midRstDrvA", bus0.drv_a, 0);
      checkOutput("midRstDrvB", bus0.drv_b, 0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("inRstBusy", busy0, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("postRstBusy%0d", k), busy0, 0);
         checkOutput($sformatf("postRstDone%0d", k), done0, 0);
         checkOutput($sformatf("postRstErr%0d", k), errCount0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
